// File: rtl/simple_req_ack_arb_pkg.sv
// Shared definitions for the round-robin req/ack arbiter:
// FSM state encoding, default parameter values and watchdog counter width.
package simple_req_ack_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int WD_CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/simple_req_ack_rr_picker.sv
// Combinational round-robin picker: returns the first set request at or
// after index ptr (wrapping modulo NUM_REQ), plus a valid flag.
module simple_req_ack_rr_picker
    import simple_req_ack_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    // cand_idx[k] is the requester index examined at priority rank k
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : sum[IDX_W-1:0];
            assign rot_req[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest rank with a pending request wins (scan high-to-low, last hit sticks)
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                winner = cand_idx[i];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_req_ack_arbiter.sv
// Round-robin arbiter bridging NUM_REQ four-phase requesters onto a single
// downstream req/ack channel. All outputs registered.
// Optional ack watchdog enabled by defining SIMPLE_REQ_ACK_ARB_TIMEOUT_EN;
// without it the timeout output is tied low and no counter exists.
module simple_req_ack_arbiter
    import simple_req_ack_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         s_req,
    output logic [NUM_REQ-1:0]         s_ack,
    output logic                       m_req,
    input  logic                       m_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   grant_reg, grant_next;
    logic               m_req_reg, m_req_next;
    logic [NUM_REQ-1:0] s_ack_reg, s_ack_next;
    logic               busy_reg;

    logic [IDX_W-1:0]   pick_winner;
    logic               pick_valid;
    logic [NUM_REQ-1:0] grant_onehot;
    logic [IDX_W-1:0]   ptr_after_grant;
    logic               req_granted;
    logic               timeout_fire;

    simple_req_ack_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (s_req),
        .ptr    (ptr_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
        end
    endgenerate

    assign req_granted     = s_req[grant_reg];
    assign ptr_after_grant = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;

`ifdef SIMPLE_REQ_ACK_ARB_TIMEOUT_EN
    localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [WD_CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic                timeout_reg;

    // A real ack on the expiry edge takes precedence over the watchdog
    assign timeout_fire = (state_reg == DRIVE) && !m_ack && (wd_cnt_reg == WD_LAST);
    // Count edges spent in DRIVE; restart from zero on every other state
    assign wd_cnt_next  = (state_reg == DRIVE && state_next == DRIVE) ? wd_cnt_reg + 1'b1 : '0;

    // Watchdog counter and one-cycle timeout pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_fire;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout_fire = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Next-state and next-output decisions for the handshake FSM
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        m_req_next = m_req_reg;
        s_ack_next = s_ack_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick_winner;
                    m_req_next = 1'b1;
                    s_ack_next = '0;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (m_ack) begin
                    if (req_granted) begin
                        s_ack_next = grant_onehot;
                        state_next = HOLD;
                    end else begin
                        // requester gave up before the downstream answered
                        m_req_next = 1'b0;
                        state_next = DRAIN;
                    end
                end else if (timeout_fire) begin
                    m_req_next = 1'b0;
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (!req_granted) begin
                    m_req_next = 1'b0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!m_ack) begin
                    s_ack_next = '0;
                    ptr_next   = ptr_after_grant;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            grant_reg <= '0;
            m_req_reg <= 1'b0;
            s_ack_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            m_req_reg <= m_req_next;
            s_ack_reg <= s_ack_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign s_ack    = s_ack_reg;
    assign m_req    = m_req_reg;
    assign grant_id = grant_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_simple_req_ack_arbiter.sv
// Self-checking bench for simple_req_ack_arbiter (NUM_REQ=4).
// Define SIMPLE_REQ_ACK_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_simple_req_ack_arbiter;

    localparam int N = 4;
`ifdef SIMPLE_REQ_ACK_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic         clock;
    logic         reset;
    logic [N-1:0] s_req;
    logic [N-1:0] s_ack;
    logic         m_req;
    logic         m_ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int txn_no = 0;

    simple_req_ack_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .s_req    (s_req),
        .s_ack    (s_ack),
        .m_req    (m_req),
        .m_ack    (m_ack),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting index scanning from p upwards, wrapping
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One complete transaction, checked step by step against the model.
    task automatic run_txn(input logic [N-1:0] vec, input bit preloaded, input bit abandon,
                           input int ack_dly, input int hold_dly, input int drain_dly,
                           input logic [N-1:0] next_vec, input bit noise, output int gnt);
        int g;
        logic [N-1:0] oh;
        g  = pick(vec, model_ptr);
        oh = '0;
        oh[g] = 1'b1;
        if (!preloaded) s_req = vec;
        @(negedge clock);
        chk("grant_id", grant_id, g);
        chk("m_req_drive", m_req, 1);
        chk("busy_drive", busy, 1);
        chk("s_ack_drive", s_ack, 0);
        for (int k = 0; k < ack_dly; k++) begin
            s_req = noise ? N'($urandom) : vec;
            s_req[g] = !abandon;
            @(negedge clock);
            chk("m_req_wait", m_req, 1);
            chk("s_ack_wait", s_ack, 0);
        end
        s_req = noise ? N'($urandom) : vec;
        s_req[g] = !abandon;
        m_ack = 1'b1;
        @(negedge clock);
        if (abandon) begin
            chk("s_ack_abandon", s_ack, 0);
            chk("m_req_abandon", m_req, 0);
            chk("busy_abandon", busy, 1);
        end else begin
            chk("s_ack_hold", s_ack, oh);
            chk("m_req_hold", m_req, 1);
            for (int k = 0; k < hold_dly; k++) begin
                s_req = noise ? N'($urandom) : vec;
                s_req[g] = 1'b1;
                @(negedge clock);
                chk("s_ack_hold_stay", s_ack, oh);
            end
            s_req = noise ? N'($urandom) : vec;
            s_req[g] = 1'b0;
            @(negedge clock);
            chk("m_req_drain", m_req, 0);
            chk("s_ack_drain", s_ack, oh);
        end
        for (int k = 0; k < drain_dly; k++) begin
            s_req = next_vec;
            @(negedge clock);
            chk("s_ack_drain_stay", s_ack, abandon ? '0 : oh);
            chk("busy_drain", busy, 1);
        end
        s_req = next_vec;
        m_ack = 1'b0;
        @(negedge clock);
        chk("busy_idle", busy, 0);
        chk("s_ack_idle", s_ack, 0);
        chk("m_req_idle", m_req, 0);
        chk("grant_kept", grant_id, g);
        chk("timeout_quiet", timeout, 0);
        model_ptr = (g + 1) % N;
        txn_no++;
        $display("txn %0d: req=%b grant=%0d abandon=%0d ack_dly=%0d", txn_no, vec, g, abandon, ack_dly);
        gnt = g;
    endtask

    initial begin
        int gnt;
        int g;
        int exp_order [8];
        logic [N-1:0] v;
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        reset = 1'b0;
        s_req = '0;
        m_ack = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_m_req", m_req, 0);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        // Single requester 2; ptr must then sit at 3
        run_txn(4'b0100, 0, 0, 1, 1, 1, 4'b0000, 0, gnt);
        chk("single_grant", gnt, 2);
        run_txn(4'b1111, 0, 0, 0, 0, 0, 4'b0000, 0, gnt);
        chk("ptr_after_single", gnt, 3);

        // All requesters held: strict rotation, with one IDLE gap each time
        for (int t = 0; t < 8; t++) begin
            run_txn(4'b1111, (t != 0), 0, t % 3, 0, 0, (t < 7) ? 4'b1111 : 4'b0000, 0, gnt);
            chk("rr_order", gnt, exp_order[t]);
        end

        // Requester 1 abandons before the downstream ack
        run_txn(4'b0010, 0, 1, 2, 0, 1, 4'b0000, 0, gnt);
        chk("abandon_grant", gnt, 1);

        // Downstream never acks
        s_req = 4'b0001;
        g = pick(4'b0001, model_ptr);
        @(negedge clock);
        chk("wd_grant", grant_id, g);
        chk("wd_m_req", m_req, 1);
`ifdef SIMPLE_REQ_ACK_ARB_TIMEOUT_EN
        for (int k = 1; k < TB_TIMEOUT; k++) begin
            @(negedge clock);
            chk("wd_no_pulse_yet", timeout, 0);
            chk("wd_m_req_held", m_req, 1);
        end
        @(negedge clock);
        chk("wd_pulse", timeout, 1);
        chk("wd_m_req_drop", m_req, 0);
        chk("wd_s_ack_low", s_ack, 0);
        chk("wd_busy_drain", busy, 1);
        s_req = '0;
        @(negedge clock);
        chk("wd_pulse_end", timeout, 0);
        chk("wd_back_idle", busy, 0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("no_wd_timeout", timeout, 0);
            chk("no_wd_m_req", m_req, 1);
            chk("no_wd_busy", busy, 1);
        end
        s_req = '0;
        m_ack = 1'b1;
        @(negedge clock);
        chk("no_wd_m_req_drop", m_req, 0);
        m_ack = 1'b0;
        @(negedge clock);
        chk("no_wd_back_idle", busy, 0);
`endif
        model_ptr = (g + 1) % N;
        $display("txn %0d: req=0001 grant=%0d watchdog scenario", ++txn_no, g);

        // Reset in the middle of HOLD on requester 3
        s_req = 4'b1000;
        @(negedge clock);
        chk("mid_rst_grant", grant_id, 3);
        m_ack = 1'b1;
        @(negedge clock);
        chk("mid_rst_hold", s_ack, 4'b1000);
        #2 reset = 1'b0;
        #1;
        chk("async_m_req", m_req, 0);
        chk("async_s_ack", s_ack, 0);
        chk("async_busy", busy, 0);
        chk("async_grant", grant_id, 0);
        s_req = 4'b1001;
        m_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_ptr = 0;
        run_txn(4'b1001, 1, 0, 1, 0, 0, 4'b0000, 0, gnt);
        chk("post_rst_first", gnt, 0);

        // Randomised traffic against the round-robin model
        for (int t = 0; t < 40; t++) begin
            v = N'($urandom_range(1, 15));
            run_txn(v, 0, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 2), 4'b0000, 1, gnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
